// File: rtl/i2c_master_byte_ctrl_pkg.sv
// Shared types for the byte-level I2C master sequencer: byte commands,
// phy bit commands and the sequencer state encoding.
package i2c_master_byte_ctrl_pkg;

    typedef enum logic [1:0] {
        B_START = 2'd0,
        B_STOP  = 2'd1,
        B_WRITE = 2'd2,
        B_READ  = 2'd3
    } byte_cmd_t;

    typedef enum logic [2:0] {
        PHY_NOP   = 3'd0,
        PHY_START = 3'd1,
        PHY_STOP  = 3'd2,
        PHY_WRITE = 3'd3,
        PHY_READ  = 3'd4
    } phy_cmd_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_BUS_WAIT,
        S_START,
        S_WR_BIT,
        S_WR_ACK,
        S_RD_BIT,
        S_RD_ACK,
        S_STOP,
        S_ABORT,
        S_RSP
    } state_t;

endpackage

// File: rtl/i2c_master_byte_ctrl_if.sv
// Byte-command handshake plus phy bit-command bundle for i2c_master_byte_ctrl.
// slave = the sequencer's view, master = the user/phy side.
interface i2c_master_byte_ctrl_if
    import i2c_master_byte_ctrl_pkg::*;
#(
    parameter int unsigned BYTE_W = 8
);

    logic              cmd_valid_i;
    logic              cmd_ready_o;
    byte_cmd_t         cmd_i;
    logic [BYTE_W-1:0] wr_data_i;
    logic              mst_nack_i;
    logic              rsp_valid_o;
    logic [BYTE_W-1:0] rd_data_o;
    logic              slv_nack_o;
    logic              arb_lost_o;
    logic              err_o;
    phy_cmd_t          phy_cmd_o;
    logic              phy_data_o;
    logic              phy_data_i;
    logic              phy_cmd_done_i;
    logic              phy_arb_lost_i;
    logic              phy_bus_busy_i;

    modport slave (
        input  cmd_valid_i, cmd_i, wr_data_i, mst_nack_i,
        input  phy_data_i, phy_cmd_done_i, phy_arb_lost_i, phy_bus_busy_i,
        output cmd_ready_o, rsp_valid_o, rd_data_o, slv_nack_o, arb_lost_o, err_o,
        output phy_cmd_o, phy_data_o
    );

    modport master (
        output cmd_valid_i, cmd_i, wr_data_i, mst_nack_i,
        output phy_data_i, phy_cmd_done_i, phy_arb_lost_i, phy_bus_busy_i,
        input  cmd_ready_o, rsp_valid_o, rd_data_o, slv_nack_o, arb_lost_o, err_o,
        input  phy_cmd_o, phy_data_o
    );

endinterface

// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C master sequencer: turns START/STOP/WRITE/READ byte commands into
// phy bit commands. Optional macro I2C_BYTE_CTRL_NACK_STOP_EN: auto-STOP after write NACK.
module i2c_master_byte_ctrl
    import i2c_master_byte_ctrl_pkg::*;
#(
    parameter int unsigned BYTE_W       = 8,
    parameter int unsigned BUS_FREE_CYC = 130
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    i2c_master_byte_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(BYTE_W);
    localparam int unsigned BF_W  = $clog2(BUS_FREE_CYC + 1);

    state_t            state_q, state_d;
    logic              owned_q, owned_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BF_W-1:0]   bus_cnt_q, bus_cnt_d;
    logic [BYTE_W-1:0] wr_data_q, wr_data_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              mst_nack_q, mst_nack_d;
    phy_cmd_t          phy_cmd_q, phy_cmd_d;
    logic              phy_data_q, phy_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [BYTE_W-1:0] rd_data_q, rd_data_d;
    logic              slv_nack_q, slv_nack_d;
    logic              arb_lost_q, arb_lost_d;
    logic              err_q, err_d;
`ifdef I2C_BYTE_CTRL_NACK_STOP_EN
    logic              nack_stop_q, nack_stop_d;
`endif

    logic             done;
    logic             cnt_zero;
    logic             bus_free_done;
    logic             arb_hit;
    logic [CNT_W-1:0] cnt_m1;

    assign done          = bus.phy_cmd_done_i;
    assign cnt_zero      = (cnt_q == '0);
    assign cnt_m1        = cnt_q - CNT_W'(1);
    assign bus_free_done = (bus_cnt_q == BF_W'(BUS_FREE_CYC - 1));

    // Arbitration only matters while we are actually driving the bus.
    always_comb begin
        arb_hit = 1'b0;
        if (bus.phy_arb_lost_i) begin
            unique case (state_q)
                S_START, S_WR_BIT, S_WR_ACK, S_RD_BIT, S_RD_ACK, S_STOP: arb_hit = 1'b1;
                default: arb_hit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            owned_q     <= 1'b0;
            cnt_q       <= '0;
            bus_cnt_q   <= '0;
            wr_data_q   <= '0;
            shift_q     <= '0;
            mst_nack_q  <= 1'b0;
            phy_cmd_q   <= PHY_NOP;
            phy_data_q  <= 1'b1;
            rsp_valid_q <= 1'b0;
            rd_data_q   <= '0;
            slv_nack_q  <= 1'b0;
            arb_lost_q  <= 1'b0;
            err_q       <= 1'b0;
`ifdef I2C_BYTE_CTRL_NACK_STOP_EN
            nack_stop_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owned_q     <= owned_d;
            cnt_q       <= cnt_d;
            bus_cnt_q   <= bus_cnt_d;
            wr_data_q   <= wr_data_d;
            shift_q     <= shift_d;
            mst_nack_q  <= mst_nack_d;
            phy_cmd_q   <= phy_cmd_d;
            phy_data_q  <= phy_data_d;
            rsp_valid_q <= rsp_valid_d;
            rd_data_q   <= rd_data_d;
            slv_nack_q  <= slv_nack_d;
            arb_lost_q  <= arb_lost_d;
            err_q       <= err_d;
`ifdef I2C_BYTE_CTRL_NACK_STOP_EN
            nack_stop_q <= nack_stop_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    if (bus.cmd_i == B_START) begin
                        state_d = owned_q ? S_START : S_BUS_WAIT;
                    end else if (!owned_q) begin
                        state_d = S_RSP;
                    end else if (bus.cmd_i == B_STOP) begin
                        state_d = S_STOP;
                    end else if (bus.cmd_i == B_WRITE) begin
                        state_d = S_WR_BIT;
                    end else begin
                        state_d = S_RD_BIT;
                    end
                end
            end
            S_BUS_WAIT: if (!bus.phy_bus_busy_i && bus_free_done) state_d = S_START;
            S_START:    if (done) state_d = S_RSP;
            S_WR_BIT:   if (done && cnt_zero) state_d = S_WR_ACK;
            S_WR_ACK: begin
                if (done) begin
`ifdef I2C_BYTE_CTRL_NACK_STOP_EN
                    state_d = bus.phy_data_i ? S_STOP : S_RSP;
`else
                    state_d = S_RSP;
`endif
                end
            end
            S_RD_BIT:   if (done && cnt_zero) state_d = S_RD_ACK;
            S_RD_ACK:   if (done) state_d = S_RSP;
            S_STOP:     if (done) state_d = S_RSP;
            S_ABORT:    if (done || phy_cmd_q == PHY_NOP) state_d = S_RSP;
            S_RSP:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (arb_hit) state_d = S_ABORT;
    end

    always_comb begin
        owned_d     = owned_q;
        cnt_d       = cnt_q;
        bus_cnt_d   = bus_cnt_q;
        wr_data_d   = wr_data_q;
        shift_d     = shift_q;
        mst_nack_d  = mst_nack_q;
        phy_cmd_d   = phy_cmd_q;
        phy_data_d  = phy_data_q;
        rd_data_d   = rd_data_q;
        slv_nack_d  = slv_nack_q;
        arb_lost_d  = arb_lost_q;
        err_d       = err_q;
        rsp_valid_d = (state_d == S_RSP);
`ifdef I2C_BYTE_CTRL_NACK_STOP_EN
        nack_stop_d = nack_stop_q;
`endif
        // On arbitration loss the in-flight bit stays on the phy until its done;
        // a coincident done means the bit is finished, so nothing further is issued.
        if (arb_hit) begin
            if (done) begin
                phy_cmd_d  = PHY_NOP;
                phy_data_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid_i) begin
                        wr_data_d  = bus.wr_data_i;
                        mst_nack_d = bus.mst_nack_i;
                        arb_lost_d = 1'b0;
                        err_d      = (state_d == S_RSP);
                        cnt_d      = CNT_W'(BYTE_W - 1);
                        bus_cnt_d  = '0;
`ifdef I2C_BYTE_CTRL_NACK_STOP_EN
                        nack_stop_d = 1'b0;
`endif
                        unique case (state_d)
                            S_START:  phy_cmd_d = PHY_START;
                            S_STOP:   phy_cmd_d = PHY_STOP;
                            S_WR_BIT: begin
                                phy_cmd_d  = PHY_WRITE;
                                phy_data_d = bus.wr_data_i[BYTE_W-1];
                            end
                            S_RD_BIT: begin
                                phy_cmd_d  = PHY_READ;
                                phy_data_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_BUS_WAIT: begin
                    if (bus.phy_bus_busy_i) begin
                        bus_cnt_d = '0;
                    end else if (state_d == S_START) begin
                        phy_cmd_d = PHY_START;
                    end else begin
                        bus_cnt_d = bus_cnt_q + BF_W'(1);
                    end
                end
                S_START: begin
                    if (done) begin
                        owned_d   = 1'b1;
                        phy_cmd_d = PHY_NOP;
                    end
                end
                S_WR_BIT: begin
                    if (done) begin
                        if (cnt_zero) begin
                            phy_cmd_d  = PHY_READ;
                            phy_data_d = 1'b1;
                        end else begin
                            cnt_d      = cnt_m1;
                            phy_data_d = wr_data_q[cnt_m1];
                        end
                    end
                end
                S_WR_ACK: begin
                    if (done) begin
                        phy_data_d = 1'b1;
                        if (state_d == S_STOP) begin
                            phy_cmd_d = PHY_STOP;
`ifdef I2C_BYTE_CTRL_NACK_STOP_EN
                            nack_stop_d = 1'b1;
`endif
                        end else begin
                            phy_cmd_d  = PHY_NOP;
                            slv_nack_d = bus.phy_data_i;
                        end
                    end
                end
                S_RD_BIT: begin
                    if (done) begin
                        shift_d = {shift_q[BYTE_W-2:0], bus.phy_data_i};
                        if (cnt_zero) begin
                            phy_cmd_d  = PHY_WRITE;
                            phy_data_d = mst_nack_q;
                        end else begin
                            cnt_d = cnt_m1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (done) begin
                        rd_data_d  = shift_q;
                        phy_cmd_d  = PHY_NOP;
                        phy_data_d = 1'b1;
                    end
                end
                S_STOP: begin
                    if (done) begin
                        owned_d   = 1'b0;
                        phy_cmd_d = PHY_NOP;
`ifdef I2C_BYTE_CTRL_NACK_STOP_EN
                        if (nack_stop_q) slv_nack_d = 1'b1;
`endif
                    end
                end
                S_ABORT: begin
                    if (state_d == S_RSP) begin
                        owned_d    = 1'b0;
                        arb_lost_d = 1'b1;
                        phy_cmd_d  = PHY_NOP;
                        phy_data_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready_o = (state_q == S_IDLE);
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rd_data_o   = rd_data_q;
    assign bus.slv_nack_o  = slv_nack_q;
    assign bus.arb_lost_o  = arb_lost_q;
    assign bus.err_o       = err_q;
    assign bus.phy_cmd_o   = phy_cmd_q;
    assign bus.phy_data_o  = phy_data_q;

endmodule
